// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - opcodes, hazard FSM state type and instruction field helpers
package pipeline_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH, REDIRECT} hz_state_e;

  function automatic logic [6:0] get_opcode(input logic [31:0] instr);
    return instr[6:0];
  endfunction

  function automatic logic [4:0] get_rd(input logic [31:0] instr);
    return instr[11:7];
  endfunction

  function automatic logic [4:0] get_rs1(input logic [31:0] instr);
    return instr[19:15];
  endfunction

  function automatic logic [4:0] get_rs2(input logic [31:0] instr);
    return instr[24:20];
  endfunction

  function automatic logic is_mem_op(input logic [6:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

  function automatic logic writes_rd(input logic [6:0] opc);
    logic w;
    case (opc)
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI,
      OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_SYSTEM: w = 1'b1;
      default:                                 w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/hazard_fwd_detect.sv
// rtl/hazard_fwd_detect.sv - combinational MW rd vs DE rs1/rs2 compare for operand forwarding
module hazard_fwd_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [31:0] instr_f,
  input  logic [31:0] instr_mw,
  input  logic        flush,
  output logic        fwd_a,
  output logic        fwd_b
);

  logic [4:0] rd;
  logic       wr;

  always_comb begin
    rd    = get_rd(instr_mw);
    // x0 is hard-wired zero, so a write to it must never be forwarded
    wr    = writes_rd(get_opcode(instr_mw)) && (rd != 5'd0) && !flush;
    fwd_a = wr && (rd == get_rs1(instr_f));
    fwd_b = wr && (rd == get_rs2(instr_f));
  end

  logic unused_bits;
  assign unused_bits = ^{instr_f[31:25], instr_f[14:0], instr_mw[31:12]};

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/redirect sequencing and forwarding; HAZARD_PERF_CNT_EN adds perf counters
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT  = 16,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instruction_F,
  input  logic [31:0] Instruction_DE,
  input  logic        dmem_ready,
  input  logic        csr_trap_req,
  input  logic        csr_mret,
  output logic        Stall_F,
  output logic        Stall_MW,
  output logic        csr_flush,
  output logic        pc_redirect,
  output logic        csr_trap_ack,
  output logic        bus_err,
  output logic        fwd_sel_a,
  output logic        fwd_sel_b
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  hz_state_e  state;
  logic [7:0] wait_cnt;
  logic [2:0] flush_cnt;
  logic       pending;
  logic       mem_start;
  logic       timeout;

  always_comb begin
    mem_start    = (state == RUN) && is_mem_op(get_opcode(Instruction_DE)) && !dmem_ready;
    timeout      = (state == MEM_WAIT) && !dmem_ready && (wait_cnt == 8'(MEM_TIMEOUT - 1));
    Stall_MW     = mem_start || ((state == MEM_WAIT) && !dmem_ready);
    Stall_F      = Stall_MW || (state == FLUSH);
    csr_flush    = (state == FLUSH);
    pc_redirect  = (state == REDIRECT);
    // only RUN may accept a trap, so an in-flight access is never cut short
    csr_trap_ack = (state == RUN) && !mem_start && csr_trap_req;
    bus_err      = timeout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= 8'd0;
      flush_cnt <= 3'd0;
      pending   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_start) begin
            state    <= MEM_WAIT;
            wait_cnt <= 8'd0;
            if (csr_trap_req) pending <= 1'b1;
          end else if (csr_trap_req || csr_mret) begin
            state     <= FLUSH;
            flush_cnt <= 3'd0;
          end
        end
        MEM_WAIT: begin
          if (csr_trap_req) pending <= 1'b1;
          if (dmem_ready) begin
            state     <= (pending || csr_trap_req) ? FLUSH : RUN;
            flush_cnt <= 3'd0;
          end else if (timeout) begin
            state     <= FLUSH;
            flush_cnt <= 3'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        FLUSH: begin
          if (flush_cnt == 3'(FLUSH_CYCLES - 1)) state <= REDIRECT;
          else flush_cnt <= flush_cnt + 3'd1;
        end
        REDIRECT: begin
          state   <= RUN;
          pending <= 1'b0;
        end
        default: state <= RUN;
      endcase
    end
  end

  hazard_fwd_detect u_fwd (
    .instr_f  (Instruction_F),
    .instr_mw (Instruction_DE),
    .flush    (csr_flush),
    .fwd_a    (fwd_sel_a),
    .fwd_b    (fwd_sel_b)
  );

`ifdef HAZARD_PERF_CNT_EN
  logic flush_entry;

  always_comb begin
    flush_entry = ((state == RUN) && !mem_start && (csr_trap_req || csr_mret)) ||
                  ((state == MEM_WAIT) && (dmem_ready ? (pending || csr_trap_req) : timeout));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= 32'd0;
      perf_flush_cnt <= 32'd0;
    end else begin
      if (Stall_MW && (perf_stall_cnt != 32'hFFFF_FFFF)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush_entry && (perf_flush_cnt != 32'hFFFF_FFFF)) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
